// File: rtl/md_issue_ctrl_pkg.sv
// Shared definitions for the mul/div issue controller: FSM state encoding,
// writeback exception codes and the operation type held while an op is in flight.
package md_issue_ctrl_pkg;

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] START = 3'd1;
  localparam logic [2:0] BUSY  = 3'd2;
  localparam logic [2:0] DONE  = 3'd3;
  localparam logic [2:0] DRAIN = 3'd4;

  localparam logic [2:0] EXC_NONE = 3'd0;
  localparam logic [2:0] EXC_MUL  = 3'd4;
  localparam logic [2:0] EXC_DIV  = 3'd5;

  typedef enum logic {
    OP_MUL = 1'b0,
    OP_DIV = 1'b1
  } md_op_e;

  function automatic logic [2:0] md_exc_code(input md_op_e op, input logic exc);
    logic [2:0] code;
    if (!exc) begin
      code = EXC_NONE;
    end else if (op == OP_MUL) begin
      code = EXC_MUL;
    end else begin
      code = EXC_DIV;
    end
    return code;
  endfunction

endpackage

// File: rtl/md_issue_ctrl_hazard_cmp.sv
// md_hazard_cmp: RAW compare of an issuing instruction's registers against the
// destination held by the in-flight mul/div op. Register 0 never hazards.
module md_hazard_cmp #(
  parameter int REG_W = 5
) (
  input  logic             en_i,
  input  logic [REG_W-1:0] held_rd_i,
  input  logic [REG_W-1:0] src_a_i,
  input  logic [REG_W-1:0] src_b_i,
  input  logic [REG_W-1:0] dst_i,
  output logic             raw_o
);

  logic match_s;

  assign match_s = (src_a_i == held_rd_i) | (src_b_i == held_rd_i) | (dst_i == held_rd_i);
  assign raw_o   = en_i & (held_rd_i != {REG_W{1'b0}}) & match_s;

endmodule

// File: rtl/md_issue_ctrl.sv
// md_issue_ctrl: issue/sequencing FSM for the multi-cycle mult/div unit.
// Optional watchdog enabled by defining MD_TIMEOUT_EN.
module md_issue_ctrl
  import md_issue_ctrl_pkg::*;
#(
  parameter int REG_W          = 5,
  parameter int TIMEOUT_CYCLES = 40
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             issue_valid,
  input  logic             issue_is_mul,
  input  logic             issue_is_div,
  input  logic [REG_W-1:0] issue_rd,
  input  logic [REG_W-1:0] issue_rs,
  input  logic [REG_W-1:0] issue_rt,
  input  logic             kill,
  input  logic             md_ready,
  input  logic             md_exception,
  input  logic             wb_ready,
  output logic             md_start_mul,
  output logic             md_start_div,
  output logic             stall,
  output logic             busy,
  output logic             wb_valid,
  output logic [REG_W-1:0] wb_rd,
  output logic [2:0]       wb_exc_code,
  output logic             md_timeout
);

  logic [2:0]       state_q, state_d;
  logic [REG_W-1:0] rd_q, rd_d;
  md_op_e           op_q, op_d;
  logic [2:0]       exc_q, exc_d;

  logic is_md_s;
  logic accept_s;
  logic timeout_hit_s;
  logic raw_en_s;
  logic raw_hit_s;
  logic structural_s;

  assign is_md_s  = issue_valid & (issue_is_mul | issue_is_div);
  assign accept_s = is_md_s & ~kill;

`ifdef MD_TIMEOUT_EN
  logic [7:0] cnt_q, cnt_d;
  logic       waiting_s;

  assign waiting_s     = (state_q == BUSY) | (state_q == DRAIN);
  assign timeout_hit_s = waiting_s & ~md_ready & (cnt_q == 8'(TIMEOUT_CYCLES - 1));

  // Wait counter restarts on every change of state, so entering BUSY or DRAIN sees zero.
  always_comb begin
    cnt_d = cnt_q;
    if (state_d != state_q) begin
      cnt_d = 8'd0;
    end else if (waiting_s) begin
      cnt_d = cnt_q + 8'd1;
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Watchdog counter register.
  always_ff @(posedge clock) begin
    if (!reset) begin
      cnt_q <= 8'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
`else
  logic [7:0] unused_timeout_cfg_s;

  assign unused_timeout_cfg_s = 8'(TIMEOUT_CYCLES);
  assign timeout_hit_s        = 1'b0;
`endif

  // Next-state and held-operand logic.
  always_comb begin
    state_d = state_q;
    rd_d    = rd_q;
    op_d    = op_q;
    exc_d   = exc_q;
    case (state_q)
      IDLE: begin
        if (accept_s) begin
          state_d = START;
          rd_d    = issue_rd;
          op_d    = issue_is_mul ? OP_MUL : OP_DIV;
          exc_d   = EXC_NONE;
        end else begin
          state_d = IDLE;
        end
      end
      START: begin
        if (kill) begin
          state_d = DRAIN;
        end else begin
          state_d = BUSY;
        end
      end
      BUSY: begin
        // A kill coinciding with the result drops it at once; no second md_ready will come.
        if (timeout_hit_s) begin
          state_d = IDLE;
        end else if (md_ready) begin
          if (kill) begin
            state_d = IDLE;
          end else begin
            state_d = DONE;
            exc_d   = md_exc_code(op_q, md_exception);
          end
        end else if (kill) begin
          state_d = DRAIN;
        end else begin
          state_d = BUSY;
        end
      end
      DONE: begin
        if (wb_ready) begin
          state_d = IDLE;
        end else begin
          state_d = DONE;
        end
      end
      DRAIN: begin
        if (timeout_hit_s || md_ready) begin
          state_d = IDLE;
        end else begin
          state_d = DRAIN;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and held-operand registers.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q <= IDLE;
      rd_q    <= {REG_W{1'b0}};
      op_q    <= OP_MUL;
      exc_q   <= EXC_NONE;
    end else begin
      state_q <= state_d;
      rd_q    <= rd_d;
      op_q    <= op_d;
      exc_q   <= exc_d;
    end
  end

  assign raw_en_s = issue_valid & ((state_q == START) | (state_q == BUSY) | (state_q == DONE));

  md_hazard_cmp #(
    .REG_W(REG_W)
  ) u_hazard_cmp (
    .en_i     (raw_en_s),
    .held_rd_i(rd_q),
    .src_a_i  (issue_rs),
    .src_b_i  (issue_rt),
    .dst_i    (issue_rd),
    .raw_o    (raw_hit_s)
  );

  assign structural_s = is_md_s & (state_q != IDLE);
  assign stall        = reset & (structural_s | raw_hit_s);

  assign md_start_mul = (state_q == START) & (op_q == OP_MUL);
  assign md_start_div = (state_q == START) & (op_q == OP_DIV);
  assign busy         = (state_q != IDLE);
  assign wb_valid     = (state_q == DONE);
  assign wb_rd        = rd_q;
  assign wb_exc_code  = exc_q;
  assign md_timeout   = timeout_hit_s;

endmodule

// File: tb/tb_md_issue_ctrl.sv
// Bench for md_issue_ctrl: directed scenarios plus a randomized run checked
// against a transaction-level model of the pending op.
module tb_md_issue_ctrl;

  localparam int REG_W = 5;
  localparam int TO    = 40;

  logic             clock = 1'b0;
  logic             reset = 1'b0;
  logic             issue_valid = 1'b0, issue_is_mul = 1'b0, issue_is_div = 1'b0;
  logic [REG_W-1:0] issue_rd = '0, issue_rs = '0, issue_rt = '0;
  logic             kill = 1'b0, md_ready = 1'b0, md_exception = 1'b0, wb_ready = 1'b0;
  logic             md_start_mul, md_start_div, stall, busy, wb_valid, md_timeout;
  logic [REG_W-1:0] wb_rd;
  logic [2:0]       wb_exc_code;

  int errors = 0;
  int checks = 0;

  // Reference model: one optional pending op described by its progress flags.
  bit             m_have, m_started, m_ready, m_discard, m_div;
  logic [REG_W-1:0] m_rd;
  logic [2:0]     m_exc;
  int             m_wait;

  always #5 clock = ~clock;

  md_issue_ctrl #(.REG_W(REG_W), .TIMEOUT_CYCLES(TO)) dut (
    .clock(clock), .reset(reset),
    .issue_valid(issue_valid), .issue_is_mul(issue_is_mul), .issue_is_div(issue_is_div),
    .issue_rd(issue_rd), .issue_rs(issue_rs), .issue_rt(issue_rt),
    .kill(kill), .md_ready(md_ready), .md_exception(md_exception), .wb_ready(wb_ready),
    .md_start_mul(md_start_mul), .md_start_div(md_start_div), .stall(stall), .busy(busy),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_exc_code(wb_exc_code), .md_timeout(md_timeout)
  );

  function automatic logic exp_timeout();
`ifdef MD_TIMEOUT_EN
    return m_have && m_started && !m_ready && (m_wait == TO - 1) && !md_ready;
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic exp_stall();
    if (!reset || !issue_valid || !m_have) return 1'b0;
    if (issue_is_mul || issue_is_div) return 1'b1;
    if (m_discard && !m_ready) return 1'b0;
    return (m_rd != 0) && (issue_rs == m_rd || issue_rt == m_rd || issue_rd == m_rd);
  endfunction

  task automatic model_step();
    if (!reset) begin
      m_have = 0; m_started = 0; m_ready = 0; m_discard = 0; m_div = 0;
      m_rd = '0; m_exc = 3'd0; m_wait = 0;
    end else if (!m_have) begin
      if (issue_valid && (issue_is_mul || issue_is_div) && !kill) begin
        m_have = 1; m_started = 0; m_ready = 0; m_discard = 0;
        m_rd = issue_rd; m_div = !issue_is_mul; m_exc = 3'd0; m_wait = 0;
      end
    end else if (!m_started) begin
      m_started = 1; m_discard = kill; m_wait = 0;
    end else if (m_ready) begin
      if (wb_ready) m_have = 0;
    end else if (exp_timeout()) begin
      m_have = 0;
    end else if (md_ready) begin
      if (m_discard || kill) m_have = 0;
      else begin
        m_ready = 1;
        m_exc = md_exception ? (m_div ? 3'd5 : 3'd4) : 3'd0;
      end
    end else if (kill && !m_discard) begin
      m_discard = 1; m_wait = 0;
    end else begin
      m_wait++;
    end
  endtask

  task automatic tick();
    @(posedge clock);
    model_step();
    @(negedge clock);
  endtask

  task automatic idle_inputs();
    reset = 1'b1; issue_valid = 1'b0; issue_is_mul = 1'b0; issue_is_div = 1'b0;
    issue_rd = '0; issue_rs = '0; issue_rt = '0;
    kill = 1'b0; md_ready = 1'b0; md_exception = 1'b0; wb_ready = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs(); issue_valid = 1; issue_is_mul = 1; issue_rd = 5'd9;
    tick(); idle_inputs(); tick();
    // now in BUSY: assert reset with a conflicting mul presented
    reset = 0; issue_valid = 1; issue_is_mul = 1; issue_rs = 5'd9; #1;
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL reset_stall_gate: got %b want 0", stall); end
    tick(); tick();
    idle_inputs(); issue_valid = 1; issue_rs = 5'd9; #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    checks++; if (wb_valid !== 1'b0) begin errors++; $display("FAIL reset_wb_valid: got %b want 0", wb_valid); end
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL reset_stall: got %b want 0", stall); end
    checks++; if ({md_start_mul, md_start_div, md_timeout} !== 3'b000) begin errors++; $display("FAIL reset_pulses: got %b want 000", {md_start_mul, md_start_div, md_timeout}); end
    checks++; if (wb_rd !== 5'd0 || wb_exc_code !== 3'd0) begin errors++; $display("FAIL reset_held: got rd=%0d code=%0d want 0 0", wb_rd, wb_exc_code); end
    idle_inputs(); md_ready = 1; md_exception = 1; tick(); idle_inputs(); #1;
    checks++; if (busy !== 1'b0 || wb_valid !== 1'b0) begin errors++; $display("FAIL idle_md_ready_ignored: got busy=%b wb=%b want 0 0", busy, wb_valid); end
  endtask

  task automatic test_mul_basic();
    int n_mul, n_div, n_wb, first_start, wb_at;
    n_mul = 0; n_div = 0; n_wb = 0; first_start = -1; wb_at = -1;
    idle_inputs(); issue_valid = 1; issue_is_mul = 1; issue_rd = 5'd7; issue_rs = 5'd1; issue_rt = 5'd2; #1;
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL mul_issue_stall: got %b want 0", stall); end
    tick();
    for (int i = 0; i < 12; i++) begin
      idle_inputs(); wb_ready = 1; md_ready = (i == 5); #1;
      if (md_start_mul) begin n_mul++; if (first_start < 0) first_start = i; end
      if (md_start_div) n_div++;
      if (wb_valid) begin
        n_wb++; wb_at = i;
        checks++; if (wb_rd !== 5'd7) begin errors++; $display("FAIL mul_wb_rd: got %0d want 7", wb_rd); end
        checks++; if (wb_exc_code !== 3'd0) begin errors++; $display("FAIL mul_wb_code: got %0d want 0", wb_exc_code); end
      end
      tick();
    end
    checks++; if (n_mul != 1 || n_div != 0) begin errors++; $display("FAIL mul_start_count: got mul=%0d div=%0d want 1 0", n_mul, n_div); end
    checks++; if (first_start != 0) begin errors++; $display("FAIL mul_start_latency: got %0d want 0", first_start); end
    checks++; if (n_wb != 1 || wb_at != 6) begin errors++; $display("FAIL mul_wb_once: got count=%0d at=%0d want 1 at 6", n_wb, wb_at); end
  endtask

  task automatic test_raw_hazard(input logic [REG_W-1:0] rd);
    logic exp_s;
    idle_inputs(); issue_valid = 1; issue_is_div = 1; issue_rd = rd; tick();
    for (int i = 0; i < 8; i++) begin
      idle_inputs(); issue_valid = 1; issue_rs = rd; issue_rt = 5'd1; issue_rd = 5'd9;
      md_ready = (i == 2); wb_ready = (i >= 5); #1;
      exp_s = (rd != 0) && (i <= 5);
      checks++; if (stall !== exp_s) begin errors++; $display("FAIL raw_stall_rd%0d_c%0d: got %b want %b", rd, i, stall, exp_s); end
      checks++; if (wb_valid !== (i >= 3 && i <= 5)) begin errors++; $display("FAIL raw_wb_valid_c%0d: got %b want %b", i, wb_valid, (i >= 3 && i <= 5)); end
      tick();
    end
  endtask

  task automatic test_kill_drain();
    int n_wb;
    n_wb = 0;
    idle_inputs(); issue_valid = 1; issue_is_mul = 1; issue_rd = 5'd5; tick();
    for (int i = 0; i < 6; i++) begin
      idle_inputs(); kill = (i == 1); md_ready = (i == 4);
      if (i == 2 || i == 3) begin issue_valid = 1; issue_rs = 5'd5; end
      #1;
      if (wb_valid) n_wb++;
      if (i == 2 || i == 3) begin
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL drain_no_raw_c%0d: got %b want 0", i, stall); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL drain_busy_c%0d: got %b want 1", i, busy); end
      end
      tick();
    end
    idle_inputs(); issue_valid = 1; issue_is_mul = 1; issue_rd = 5'd6; #1;
    checks++; if (n_wb != 0) begin errors++; $display("FAIL drain_wb_count: got %0d want 0", n_wb); end
    checks++; if (busy !== 1'b0 || stall !== 1'b0) begin errors++; $display("FAIL drain_exit: got busy=%b stall=%b want 0 0", busy, stall); end
    tick(); idle_inputs(); #1;
    checks++; if (md_start_mul !== 1'b1 || wb_rd !== 5'd6) begin errors++; $display("FAIL drain_next_mul: got start=%b rd=%0d want 1 6", md_start_mul, wb_rd); end
    md_ready = 1; tick(); tick(); wb_ready = 1; md_ready = 0; tick(); idle_inputs();
  endtask

  task automatic test_exception(input bit is_div, input logic [REG_W-1:0] rd, input logic [2:0] code);
    int n_wb;
    n_wb = 0;
    idle_inputs(); issue_valid = 1; issue_is_div = is_div; issue_is_mul = !is_div; issue_rd = rd; tick();
    for (int i = 0; i < 8; i++) begin
      idle_inputs(); md_ready = (i == 1); md_exception = (i == 1); wb_ready = (i >= 5); #1;
      if (wb_valid) begin
        n_wb++;
        checks++; if (wb_exc_code !== code || wb_rd !== rd) begin errors++; $display("FAIL exc_hold_c%0d: got code=%0d rd=%0d want %0d %0d", i, wb_exc_code, wb_rd, code, rd); end
      end
      tick();
    end
    checks++; if (n_wb != 4) begin errors++; $display("FAIL exc_wb_cycles: got %0d want 4", n_wb); end
  endtask

  task automatic test_back_to_back();
    idle_inputs(); issue_valid = 1; issue_is_mul = 1; issue_rd = 5'd4; tick();
    idle_inputs(); tick();
    md_ready = 1; tick();
    idle_inputs(); wb_ready = 1; issue_valid = 1; issue_is_div = 1; issue_rd = 5'd8; #1;
    checks++; if (wb_valid !== 1'b1 || stall !== 1'b1) begin errors++; $display("FAIL b2b_done_stall: got wb=%b stall=%b want 1 1", wb_valid, stall); end
    tick(); #1;
    checks++; if (busy !== 1'b0 || stall !== 1'b0) begin errors++; $display("FAIL b2b_idle_accept: got busy=%b stall=%b want 0 0", busy, stall); end
    tick(); idle_inputs(); #1;
    checks++; if (md_start_div !== 1'b1 || wb_rd !== 5'd8) begin errors++; $display("FAIL b2b_start: got start=%b rd=%0d want 1 8", md_start_div, wb_rd); end
    md_ready = 1; tick(); tick(); wb_ready = 1; md_ready = 0; tick(); idle_inputs();
  endtask

  task automatic test_timeout();
    int n_to, to_at;
    n_to = 0; to_at = -1;
    idle_inputs(); issue_valid = 1; issue_is_mul = 1; issue_rd = 5'd2; tick();
    for (int i = 0; i < 50; i++) begin
      idle_inputs(); #1;
      if (md_timeout) begin n_to++; to_at = i; end
`ifdef MD_TIMEOUT_EN
      if (i == 41) begin
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL timeout_idle: got busy=%b want 0", busy); end
      end
`endif
      tick();
    end
`ifdef MD_TIMEOUT_EN
    checks++; if (n_to != 1 || to_at != TO) begin errors++; $display("FAIL timeout_pulse: got count=%0d at=%0d want 1 at %0d", n_to, to_at, TO); end
`else
    checks++; if (n_to != 0 || busy !== 1'b1) begin errors++; $display("FAIL no_timeout_wait: got count=%0d busy=%b want 0 1", n_to, busy); end
`endif
    md_ready = 1; tick(); idle_inputs(); wb_ready = 1; tick(); tick(); #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL timeout_recover: got busy=%b want 0", busy); end
  endtask

  task automatic test_random();
    for (int i = 0; i < 2500; i++) begin
      reset        = ($urandom_range(0, 299) != 0);
      issue_valid  = 1'($urandom_range(0, 1));
      issue_is_mul = ($urandom_range(0, 3) == 0);
      issue_is_div = ($urandom_range(0, 3) == 0);
      issue_rd     = 5'($urandom_range(0, 3));
      issue_rs     = 5'($urandom_range(0, 3));
      issue_rt     = 5'($urandom_range(0, 3));
      kill         = ($urandom_range(0, 9) == 0);
      md_ready     = ($urandom_range(0, 3) == 0);
      md_exception = 1'($urandom_range(0, 1));
      wb_ready     = ($urandom_range(0, 4) < 3);
      #1;
      checks++; if (stall !== exp_stall()) begin errors++; $display("FAIL rnd_stall_%0d: got %b want %b", i, stall, exp_stall()); end
      checks++; if (busy !== m_have) begin errors++; $display("FAIL rnd_busy_%0d: got %b want %b", i, busy, m_have); end
      checks++; if (md_start_mul !== (m_have && !m_started && !m_div)) begin errors++; $display("FAIL rnd_start_mul_%0d: got %b", i, md_start_mul); end
      checks++; if (md_start_div !== (m_have && !m_started && m_div)) begin errors++; $display("FAIL rnd_start_div_%0d: got %b", i, md_start_div); end
      checks++; if (wb_valid !== (m_have && m_ready)) begin errors++; $display("FAIL rnd_wb_valid_%0d: got %b want %b", i, wb_valid, (m_have && m_ready)); end
      checks++; if (wb_rd !== m_rd) begin errors++; $display("FAIL rnd_wb_rd_%0d: got %0d want %0d", i, wb_rd, m_rd); end
      checks++; if (wb_exc_code !== m_exc) begin errors++; $display("FAIL rnd_exc_%0d: got %0d want %0d", i, wb_exc_code, m_exc); end
      checks++; if (md_timeout !== exp_timeout()) begin errors++; $display("FAIL rnd_timeout_%0d: got %b want %b", i, md_timeout, exp_timeout()); end
      tick();
    end
  endtask

  initial begin
    idle_inputs(); reset = 1'b0;
    tick(); tick();
    test_reset();
    test_mul_basic();
    test_raw_hazard(5'd3);
    test_raw_hazard(5'd0);
    test_kill_drain();
    test_exception(1'b1, 5'd12, 3'd5);
    test_exception(1'b0, 5'd0, 3'd4);
    test_back_to_back();
    test_timeout();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
